// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiply-accumulate unit.
// Holds the default operand width and the controller state encoding.
package mult_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/shift_add_multiplier_add_nbit.sv
// Parameterised N-bit ripple-carry adder built from a chain of full-adder cells.
// The multiplier uses one of these for the accumulate step.
module add_nbit #(
    parameter int N = 16
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] S,
    output logic         Cout
);

    logic [N:0] carry_s;

    assign carry_s[0] = Cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign S[i]         = A[i] ^ B[i] ^ carry_s[i];
        assign carry_s[i+1] = (A[i] & B[i]) | (A[i] & carry_s[i]) | (B[i] & carry_s[i]);
    end

    assign Cout = carry_s[N];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiply-accumulate: p = a*b + c over WIDTH RUN cycles,
// with a start/busy/done handshake so a controller can sequence it.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     c,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    mult_state_t   state_q, state_d;
    logic [PW-1:0] acc_q,   acc_d;
    logic [PW-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [PW-1:0] p_q,     p_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;

    logic [PW-1:0] sum_s;
    logic          unused_cout_s;

    // The operands never exceed 2^(2W) - 2^W, so the carry-out is always zero.
    add_nbit #(
        .N (PW)
    ) u_add (
        .A    (acc_q),
        .B    (mcand_q),
        .Cin  (1'b0),
        .S    (sum_s),
        .Cout (unused_cout_s)
    );

    // Next-state, datapath and output decode for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mq_d    = mq_q;
        cnt_d   = cnt_q;
        p_d     = p_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = {{WIDTH{1'b0}}, a};
                    mq_d    = b;
                    acc_d   = {{WIDTH{1'b0}}, c};
                    cnt_d   = {CW{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (mq_q[0]) begin
                    acc_d = sum_s;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d = mcand_q << 1;
                mq_d    = mq_q >> 1;
                cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                // The last iteration's add is folded straight into the published result.
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    p_d     = acc_d;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= {PW{1'b0}};
            mcand_q <= {PW{1'b0}};
            mq_q    <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            p_q     <= {PW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mq_q    <= mq_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: a timing/arithmetic model queues expected
// results on each modelled accept; a negedge monitor checks every done, busy and p.
module tb_shift_add_multiplier;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   c;
    logic           busy;
    logic           done;
    logic [2*W-1:0] p;

    typedef struct {
        logic [2*W-1:0] p;
        int unsigned    cyc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc;
    int unsigned rem;
    int          checks;
    int          failures;
    int          done_cnt;

    shift_add_multiplier #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c     (c),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accept happens whenever the unit is free and start is high;
    // it stays occupied for W+1 cycles and delivers a*b+c W edges after the accept.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rem <= 0;
            exp_q.delete();
        end else begin
            cyc <= cyc + 1;
            if (rem == 0 && start) begin
                exp_q.push_back('{p: (2*W)'(a) * (2*W)'(b) + (2*W)'(c), cyc: cyc + 1 + W});
                rem <= W + 1;
            end else if (rem != 0) begin
                rem <= rem - 1;
            end
        end
    end

    // Monitor: compares outputs against the model every falling edge.
    initial begin : monitor
        logic [2*W-1:0] held;
        logic           prev_done;
        exp_t           e;
        held      = '0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held      = '0;
                prev_done = 1'b0;
            end else begin
                if (done) begin
                    done_cnt = done_cnt + 1;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result_p", 32'(p), 32'(e.p));
                        chk("done_cycle", cyc, e.cyc);
                        held = e.p;
                    end
                    chk("done_twice", 32'(prev_done), 32'd0);
                end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
                    e = exp_q.pop_front();
                    chk("missed_done", cyc, e.cyc);
                end
                chk("busy", 32'(busy), 32'(rem != 0));
                chk("p_held", 32'(p), 32'(held));
                prev_done = done;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rem != 0 || exp_q.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (rem != 0 || exp_q.size() != 0) begin
            chk("idle_timeout", 32'd1, 32'd0);
        end
    endtask

    // One operation; inputs are scrambled mid-RUN and optionally start is pulsed in DONE.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] ic, input bit pulse_in_done);
        int n;
        wait_idle();
        @(negedge clk);
        a     = ia;
        b     = ib;
        c     = ic;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        c     = W'($urandom);
        if (pulse_in_done) begin
            n = 0;
            while (!done && n < 20) begin
                @(negedge clk);
                n++;
            end
            start = 1'b1;
            a     = W'($urandom);
            b     = W'($urandom);
            c     = W'($urandom);
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle();
    endtask

    logic [W-1:0]   dir_a [7] = '{8'd13, 8'd255, 8'd0, 8'd37, 8'd1,   8'd28, 8'd200};
    logic [W-1:0]   dir_b [7] = '{8'd11, 8'd255, 8'd0, 8'd0,  8'd255, 8'd7,  8'd1};
    logic [W-1:0]   dir_c [7] = '{8'd7,  8'd255, 8'd0, 8'd200, 8'd0,  8'd4,  8'd55};
    logic [2*W-1:0] dir_p [7] = '{16'd150, 16'd65280, 16'd0, 16'd200, 16'd255, 16'd200, 16'd255};

    initial begin
        int d0;
        checks   = 0;
        failures = 0;
        done_cnt = 0;
        cyc      = 0;
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        c        = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_p", 32'(p), 32'd0);

        for (int i = 0; i < 7; i++) begin
            do_op(dir_a[i], dir_b[i], dir_c[i], (i % 2) == 1);
            chk("directed_p", 32'(p), 32'(dir_p[i]));
        end

        for (int i = 0; i < 20; i++) begin
            do_op(W'($urandom), W'($urandom), W'($urandom), ($urandom_range(0, 1) == 1));
        end

        // Start held high: one accept every W+2 cycles, each from its own accept-edge inputs.
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = W'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();
        chk("held_start_results", 32'(done_cnt - d0), 32'd6);

        // Asynchronous reset in the middle of RUN aborts without a done pulse.
        @(negedge clk);
        a     = 8'd200;
        b     = 8'd100;
        c     = 8'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_p", 32'(p), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        d0 = done_cnt;
        repeat (15) @(negedge clk);
        chk("no_done_after_abort", 32'(done_cnt - d0), 32'd0);

        do_op(8'd13, 8'd11, 8'd7, 1'b0);
        chk("post_reset_p", 32'(p), 32'd150);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
